procb_thread_sched: RTL
=======================

# procb_thread_sched

Per-thread scheduler for the process_bytes stage of the md5crypt engine. Picks the next ready thread round-robin and restores its saved procb state from the per-thread saved-state store into the process_bytes engine. On completion it writes back the unfinished-record state if the engine requests it. It sits between the thread request lines, the saved-state store (async-read, sync-write distributed RAM) and the process_bytes engine.

## Interface
- N_THREADS, 6, number of threads sharing the engine
- N_THREADS_MSB, `MSB(N_THREADS-1), MSB of a thread number

- CLK  in  1  clock; all logic on posedge
- RST  in  1  synchronous, active-high reset
- thread_req  in  N_THREADS  bit i: thread i has a block pending
- thread_done  out  N_THREADS  one-hot 1-cycle pulse: block for thread finished
- busy  out  1  scheduler not in IDLE
- rd_thread_num  out  N_THREADS_MSB+1  read address to saved-state store
- state_in  in  `PROCB_SAVE_WIDTH  store read data (combinational from rd_thread_num)
- wr_en  out  1  store write enable
- wr_thread_num  out  N_THREADS_MSB+1  store write address
- dout  out  `PROCB_SAVE_WIDTH  store write data
- eng_start  out  1  1-cycle start pulse to engine
- eng_thread_num  out  N_THREADS_MSB+1  thread being processed
- eng_state  out  `PROCB_SAVE_WIDTH  restored state, stable from eng_start to next LOAD
- eng_done  in  1  engine finished current block (1-cycle pulse)
- eng_save  in  1  qualifies eng_done: state must be saved (record unfinished)
- eng_state_out  in  `PROCB_SAVE_WIDTH  state to save, valid with eng_done

## Operation
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE:
  - If any thread_req bit is set, choose the first set bit searching from last_grant+1 upward, wrapping at N_THREADS-1 to 0.
  - Register it into sel and last_grant, then go to LOAD. Otherwise stay.
- LOAD: rd_thread_num = sel. Capture state_in into eng_state and sel into eng_thread_num. Set eng_start for the next cycle. Go to RUN.
- RUN:
  - eng_start is high in the first RUN cycle only.
  - eng_done is ignored while eng_start is high.
  - On eng_done: latch eng_save into save_flag and eng_state_out into the save register. Go to FIN.
- FIN:
  - wr_en = save_flag, wr_thread_num = sel, dout = save register.
  - thread_done[sel] = 1.
  - Go to IDLE.
- thread_req is not cleared by the scheduler. The requester must drop bit sel no later than the cycle after the thread_done pulse. A bit still set in IDLE is a new request.
- Round-robin pointer last_grant resets to N_THREADS-1, so thread 0 is served first after reset.
- Thread numbers ≥ N_THREADS are never produced.
- Reset mid-operation:
  - FSM returns to IDLE and the pointer resets.
  - No write is issued; a pending save is discarded.
  - All outputs return to their reset values in the cycle after RST is sampled high.

## Timing
- Reset values:
  - 0: eng_start, wr_en, thread_done, busy, eng_state, dout, eng_thread_num, wr_thread_num, rd_thread_num.
  - IDLE; last_grant = N_THREADS-1.
- Request seen in IDLE at cycle t:
  - LOAD at t+1.
  - eng_start and stable eng_state at t+2.
- eng_done at cycle d: FIN at d+1, with the wr_en and thread_done pulses. IDLE at d+2.
- Minimum turnaround from eng_done to the next eng_start is 4 cycles (FIN, IDLE, LOAD, RUN).
- Writes are exactly one cycle long. Reads are not registered by the store; the LOAD capture is the only sampling point.
- A write in FIN to thread k and a later LOAD of thread k are always ≥2 cycles apart, so the read returns the written data.
- busy is high in LOAD, RUN and FIN.

## Structure
- `PROCB_SAVE_WIDTH and `MSB live in the shared md5.vh header.
- FSM state encodings are local.
- One sub-module, procb_rr_pick, is natural: combinational round-robin search that maps (req, last_grant) to (any, idx), parameterized by N_THREADS.

## Test plan
- Reset, then thread_req=6'b000001 → LOAD reads thread 0; eng_start at cycle 2 with eng_state = mem[0] and eng_thread_num=0. eng_done with eng_save=0 → wr_en stays 0; thread_done=6'b000001 for 1 cycle.
- All six requests held, each run ends with eng_done → grant order 0,1,2,3,4,5,0. Each thread_done is one-hot for exactly 1 cycle.
- Thread 3 finishes with eng_save=1 and eng_state_out=X → wr_en=1, wr_thread_num=3, dout=X for 1 cycle. The next service of thread 3 shows eng_state=X.
- last_grant=4 and thread_req=6'b010001 → thread 0 granted (wrap past 5), not thread 4.
- RST pulsed for 1 cycle while in RUN, then eng_done=1 with eng_save=1 → no wr_en and no thread_done. FSM in IDLE; next grant is thread 0.
- eng_done asserted in the same cycle as eng_start → ignored. A later eng_done completes normally.

Source files
------------

// File: rtl/procb_thread_sched_pkg.sv
// Shared constants, FSM encoding and width helper for the process_bytes thread scheduler.
package procb_thread_sched_pkg;

    localparam int PROCB_SAVE_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } sched_state_t;

    // Index of the highest set bit; sizes thread-number fields from N_THREADS-1.
    function automatic int msb(input int v);
        int m;
        m = 0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) m = i;
        end
        return m;
    endfunction

endpackage

// File: rtl/procb_rr_pick.sv
// Combinational round-robin search: first set req bit after last_grant, wrapping to 0.
module procb_rr_pick
    import procb_thread_sched_pkg::*;
#(
    parameter int N_THREADS = 6,
    localparam int TW = msb(N_THREADS - 1) + 1
) (
    input  logic [N_THREADS-1:0] req,
    input  logic [TW-1:0]        last_grant,
    output logic                 any,
    output logic [TW-1:0]        idx
);

    int cand;

    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = 0;
        for (int k = 1; k <= N_THREADS; k++) begin
            cand = (int'(last_grant) + k) % N_THREADS;
            if (!any && req[cand[TW-1:0]]) begin
                any = 1'b1;
                idx = TW'(cand);
            end
        end
    end

endmodule

// File: rtl/procb_thread_sched.sv
// Round-robin scheduler restoring/saving per-thread procb state around process_bytes runs.
module procb_thread_sched
    import procb_thread_sched_pkg::*;
#(
    parameter int N_THREADS = 6,
    localparam int TW = msb(N_THREADS - 1) + 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [N_THREADS-1:0]        thread_req,
    output logic [N_THREADS-1:0]        thread_done,
    output logic                        busy,
    output logic [TW-1:0]               rd_thread_num,
    input  logic [PROCB_SAVE_WIDTH-1:0] state_in,
    output logic                        wr_en,
    output logic [TW-1:0]               wr_thread_num,
    output logic [PROCB_SAVE_WIDTH-1:0] dout,
    output logic                        eng_start,
    output logic [TW-1:0]               eng_thread_num,
    output logic [PROCB_SAVE_WIDTH-1:0] eng_state,
    input  logic                        eng_done,
    input  logic                        eng_save,
    input  logic [PROCB_SAVE_WIDTH-1:0] eng_state_out
);

    localparam logic [N_THREADS-1:0] ONE_HOT0 = N_THREADS'(1);

    sched_state_t  state;
    logic [TW-1:0] sel;
    logic [TW-1:0] last_grant;
    logic          pick_any;
    logic [TW-1:0] pick_idx;

    procb_rr_pick #(.N_THREADS(N_THREADS)) u_pick (
        .req        (thread_req),
        .last_grant (last_grant),
        .any        (pick_any),
        .idx        (pick_idx)
    );

    // The store reads asynchronously; sel is stable throughout LOAD.
    assign rd_thread_num = sel;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= ST_IDLE;
            sel            <= '0;
            last_grant     <= TW'(N_THREADS - 1);
            busy           <= 1'b0;
            eng_start      <= 1'b0;
            eng_thread_num <= '0;
            eng_state      <= '0;
            wr_en          <= 1'b0;
            wr_thread_num  <= '0;
            dout           <= '0;
            thread_done    <= '0;
        end else begin
            eng_start   <= 1'b0;
            wr_en       <= 1'b0;
            thread_done <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        sel        <= pick_idx;
                        last_grant <= pick_idx;
                        busy       <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    eng_state      <= state_in;
                    eng_thread_num <= sel;
                    eng_start      <= 1'b1;
                    state          <= ST_RUN;
                end
                ST_RUN: begin
                    // A done coincident with the start pulse belongs to no block.
                    if (eng_done && !eng_start) begin
                        wr_en         <= eng_save;
                        wr_thread_num <= sel;
                        dout          <= eng_state_out;
                        thread_done   <= ONE_HOT0 << sel;
                        state         <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
